// File: rtl/asr_ring_mc.sv
`default_nettype none
// ---- asr_ring_mc : multi-channel circular-buffer delay line with ----
// ---- registered tap read, fill masking and flush.   rev 1.0     ----
module asr_ring_mc #(
  parameter int WIDTH_DATA = 8,
  parameter int N_TAPS     = 16,
  parameter int N_CH       = 2
) (
  input  logic                                    clk,
  input  logic                                    clr,
  input  logic                                    en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_wr,
  input  logic [WIDTH_DATA-1:0]                   d,
  input  logic                                    flush,
  input  logic                                    rd,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_rd,
  input  logic [$clog2(N_TAPS)-1:0]               add,
  output logic [WIDTH_DATA-1:0]                   q,
  output logic                                    q_valid,
  output logic [N_CH-1:0]                         full
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW  = $clog2(N_TAPS);
  localparam int FW  = $clog2(N_TAPS + 1);
  localparam int MW  = $clog2(N_CH * N_TAPS);

  logic [WIDTH_DATA-1:0] r_mem   [N_CH*N_TAPS];
  logic [PW-1:0]         r_wptr  [N_CH];
  logic [FW-1:0]         r_fill  [N_CH];
  logic [N_CH-1:0]       r_full;
  logic [WIDTH_DATA-1:0] r_q;
  logic                  r_q_valid;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [CHW-1:0]        w_wr_ch;
  logic [CHW-1:0]        w_rd_ch;
  logic [MW-1:0]         w_widx;
  logic [MW-1:0]         w_ridx;
  logic                  w_mask;
  logic [31:0]           w_pos;

  always_comb begin
    w_wr_ok = ({1'b0, ch_wr} < (CHW+1)'(N_CH));
    w_rd_ok = ({1'b0, ch_rd} < (CHW+1)'(N_CH));
    w_wr_ch = w_wr_ok ? ch_wr : '0;
    w_rd_ch = w_rd_ok ? ch_rd : '0;
    w_widx  = MW'(32'(w_wr_ch) * N_TAPS + 32'(r_wptr[w_wr_ch]));
    w_mask  = !w_rd_ok || (32'(add) >= N_TAPS) ||
              (32'(add) >= 32'(r_fill[w_rd_ch]));
    // Offset by N_TAPS before subtracting so the modulo works for any depth.
    w_pos   = '0;
    if (!w_mask) begin
      w_pos = 32'(r_wptr[w_rd_ch]) + N_TAPS - 1 - 32'(add);
      if (w_pos >= N_TAPS)
        w_pos = w_pos - N_TAPS;
    end
    w_ridx  = MW'(32'(w_rd_ch) * N_TAPS + w_pos);
  end

  always_ff @(posedge clk) begin
    if (en && w_wr_ok && !flush)
      r_mem[w_widx] <= d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_full    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_wptr[c] <= '0;
        r_fill[c] <= '0;
      end
    end else begin
      r_q_valid <= rd;
      if (rd)
        r_q <= w_mask ? '0 : r_mem[w_ridx];
      if (flush) begin
        r_full <= '0;
        for (int c = 0; c < N_CH; c++) begin
          r_wptr[c] <= '0;
          r_fill[c] <= '0;
        end
      end else if (en && w_wr_ok) begin
        r_wptr[w_wr_ch] <= (r_wptr[w_wr_ch] == PW'(N_TAPS - 1)) ?
                           '0 : r_wptr[w_wr_ch] + 1'b1;
        if (r_fill[w_wr_ch] != FW'(N_TAPS))
          r_fill[w_wr_ch] <= r_fill[w_wr_ch] + 1'b1;
        r_full[w_wr_ch] <= (r_fill[w_wr_ch] >= FW'(N_TAPS - 1));
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign full    = r_full;

endmodule
`default_nettype wire

// File: tb/tb_asr_ring_mc.sv
`default_nettype none
// Bench for asr_ring_mc: a 16x2 instance and a 5x3 instance, read results
// checked against a queue of expected taps.
module tb_asr_ring_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N_TAPS=16, N_CH=2
  logic       clr_a = 1'b1, en_a = 1'b0, flush_a = 1'b0, rd_a = 1'b0;
  logic [0:0] chw_a = '0, chr_a = '0;
  logic [7:0] d_a = '0;
  logic [3:0] add_a = '0;
  logic [7:0] q_a;
  logic       qv_a;
  logic [1:0] full_a;
  logic       ev_a = 1'b0;
  logic [7:0] qa[$];

  // Instance B: N_TAPS=5, N_CH=3
  logic       clr_b = 1'b1, en_b = 1'b0, flush_b = 1'b0, rd_b = 1'b0;
  logic [1:0] chw_b = '0, chr_b = '0;
  logic [7:0] d_b = '0;
  logic [2:0] add_b = '0;
  logic [7:0] q_b;
  logic       qv_b;
  logic [2:0] full_b;
  logic       ev_b = 1'b0;
  logic [7:0] qb[$];

  asr_ring_mc #(.WIDTH_DATA(8), .N_TAPS(16), .N_CH(2)) u_a (
    .clk(clk), .clr(clr_a), .en(en_a), .ch_wr(chw_a), .d(d_a),
    .flush(flush_a), .rd(rd_a), .ch_rd(chr_a), .add(add_a),
    .q(q_a), .q_valid(qv_a), .full(full_a));

  asr_ring_mc #(.WIDTH_DATA(8), .N_TAPS(5), .N_CH(3)) u_b (
    .clk(clk), .clr(clr_b), .en(en_b), .ch_wr(chw_b), .d(d_b),
    .flush(flush_b), .rd(rd_b), .ch_rd(chr_b), .add(add_b),
    .q(q_b), .q_valid(qv_b), .full(full_b));

  always @(posedge clk or posedge clr_a) if (clr_a) ev_a <= 1'b0; else ev_a <= rd_a;
  always @(posedge clk or posedge clr_b) if (clr_b) ev_b <= 1'b0; else ev_b <= rd_b;

  // Scoreboard pop: q_valid must follow rd by one cycle, q must match queue head.
  always @(negedge clk) begin
    logic [7:0] ex;
    if (!clr_a) begin
      checks++;
      if (qv_a !== ev_a) begin
        errors++; $display("FAIL a_q_valid: got %b expected %b at %0t", qv_a, ev_a, $time);
      end
      if (ev_a) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL a_sb_empty: got q=%h expected no pending read", q_a);
        end else begin
          ex = qa.pop_front();
          if (q_a !== ex) begin
            errors++; $display("FAIL a_q: got %h expected %h at %0t", q_a, ex, $time);
          end
        end
      end
    end
    if (!clr_b) begin
      checks++;
      if (qv_b !== ev_b) begin
        errors++; $display("FAIL b_q_valid: got %b expected %b at %0t", qv_b, ev_b, $time);
      end
      if (ev_b) begin
        checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL b_sb_empty: got q=%h expected no pending read", q_b);
        end else begin
          ex = qb.pop_front();
          if (q_b !== ex) begin
            errors++; $display("FAIL b_q: got %h expected %h at %0t", q_b, ex, $time);
          end
        end
      end
    end
  end

  task automatic step_a(input logic e, input logic [0:0] cw, input logic [7:0] dd,
                        input logic r, input logic [0:0] cr, input logic [3:0] ad,
                        input logic fl, input logic [7:0] ex);
    en_a = e; chw_a = cw; d_a = dd; rd_a = r; chr_a = cr; add_a = ad; flush_a = fl;
    if (r) qa.push_back(ex);
    @(posedge clk); #1;
    en_a = 1'b0; rd_a = 1'b0; flush_a = 1'b0;
  endtask

  task automatic a_wr(input logic [0:0] ch, input logic [7:0] dd);
    step_a(1'b1, ch, dd, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic a_rd(input logic [0:0] ch, input logic [3:0] ad, input logic [7:0] ex);
    step_a(1'b0, 1'b0, 8'h00, 1'b1, ch, ad, 1'b0, ex);
  endtask

  task automatic step_b(input logic e, input logic [1:0] cw, input logic [7:0] dd,
                        input logic r, input logic [1:0] cr, input logic [2:0] ad,
                        input logic [7:0] ex);
    en_b = e; chw_b = cw; d_b = dd; rd_b = r; chr_b = cr; add_b = ad;
    if (r) qb.push_back(ex);
    @(posedge clk); #1;
    en_b = 1'b0; rd_b = 1'b0;
  endtask

  task automatic pulse_clr_a;
    @(negedge clk); #1;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
  endtask

  task automatic pulse_clr_b;
    @(negedge clk); #1;
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (q_a !== 8'h00 || qv_a !== 1'b0 || full_a !== 2'b00) begin
      errors++; $display("FAIL reset_a: got q=%h v=%b full=%b expected 00 0 00", q_a, qv_a, full_a);
    end
    checks++;
    if (q_b !== 8'h00 || qv_b !== 1'b0 || full_b !== 3'b000) begin
      errors++; $display("FAIL reset_b: got q=%h v=%b full=%b expected 00 0 000", q_b, qv_b, full_b);
    end
    @(posedge clk); #1;
    clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic test_zero_mask;
    a_wr(0, 8'h11); a_wr(0, 8'h22); a_wr(0, 8'h33);
    a_rd(0, 0, 8'h33); a_rd(0, 1, 8'h22); a_rd(0, 2, 8'h11); a_rd(0, 3, 8'h00);
    a_rd(1, 0, 8'h00);
  endtask

  task automatic test_wrap_full;
    pulse_clr_a();
    for (int i = 1; i <= 20; i++) begin
      a_wr(1, 8'(i));
      if (i == 15) begin
        checks++;
        if (full_a !== 2'b00) begin
          errors++; $display("FAIL full_15: got %b expected 00", full_a);
        end
      end
      if (i == 16) begin
        checks++;
        if (full_a !== 2'b10) begin
          errors++; $display("FAIL full_16: got %b expected 10", full_a);
        end
      end
    end
    checks++;
    if (full_a !== 2'b10) begin
      errors++; $display("FAIL full_20: got %b expected 10", full_a);
    end
    a_rd(1, 0, 8'd20); a_rd(1, 15, 8'd5); a_rd(1, 7, 8'd13); a_rd(0, 0, 8'h00);
  endtask

  task automatic test_isolation;
    pulse_clr_a();
    for (int i = 0; i < 8; i++) begin
      a_wr(0, 8'hA0 + 8'(i));
      a_wr(1, 8'hB0 + 8'(i));
    end
    a_rd(0, 2, 8'hA5); a_rd(1, 7, 8'hB0); a_rd(0, 7, 8'hA0); a_rd(1, 8, 8'h00);
    checks++;
    if (full_a !== 2'b00) begin
      errors++; $display("FAIL iso_full: got %b expected 00", full_a);
    end
  endtask

  task automatic test_back_to_back;
    pulse_clr_a();
    a_wr(0, 8'h11); a_wr(0, 8'h22); a_wr(0, 8'h33);
    step_a(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 4'd0, 1'b0, 8'h33);
    a_rd(0, 0, 8'h44); a_rd(0, 1, 8'h33); a_rd(0, 3, 8'h11);
  endtask

  task automatic test_flush;
    pulse_clr_a();
    for (int i = 1; i <= 16; i++) a_wr(0, 8'(i));
    checks++;
    if (full_a !== 2'b01) begin
      errors++; $display("FAIL flush_pre_full: got %b expected 01", full_a);
    end
    step_a(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 4'd0, 1'b1, 8'd16);
    checks++;
    if (full_a !== 2'b00) begin
      errors++; $display("FAIL flush_full: got %b expected 00", full_a);
    end
    step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    checks++;
    if (q_a !== 8'd16) begin
      errors++; $display("FAIL flush_q_hold: got %h expected 10", q_a);
    end
    a_rd(0, 0, 8'h00);
    a_wr(0, 8'h66);
    a_rd(0, 0, 8'h66); a_rd(0, 1, 8'h00);
  endtask

  task automatic test_nonpow2;
    pulse_clr_b();
    for (int i = 1; i <= 7; i++) step_b(1'b1, 2'd2, 8'(i), 1'b0, 2'd0, 3'd0, 8'h00);
    checks++;
    if (full_b !== 3'b100) begin
      errors++; $display("FAIL b_full: got %b expected 100", full_b);
    end
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd4, 8'd3);
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd6, 8'd0);
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd7, 8'd0);
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd1, 8'd6);
    step_b(1'b1, 2'd3, 8'h99, 1'b1, 2'd3, 3'd0, 8'd0);
    checks++;
    if (full_b !== 3'b100) begin
      errors++; $display("FAIL b_bad_ch_write: got full %b expected 100", full_b);
    end
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd0, 8'd7);
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 3'd0, 8'd0);
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd0, 8'd7);
    @(negedge clk); #1;
    clr_b = 1'b1;
    #1;
    checks++;
    if (q_b !== 8'h00 || qv_b !== 1'b0 || full_b !== 3'b000) begin
      errors++; $display("FAIL b_async_clr: got q=%h v=%b full=%b expected 00 0 000", q_b, qv_b, full_b);
    end
    @(posedge clk); #1;
    clr_b = 1'b0;
    step_b(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 3'd0, 8'd0);
  endtask

  initial begin
    test_reset();
    test_zero_mask();
    test_wrap_full();
    test_isolation();
    test_back_to_back();
    test_flush();
    test_nonpow2();
    @(negedge clk); #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
